// File: rtl/scarv_soc_bram_arbiter_pkg.sv
// Shared definitions for the SoC BRAM arbiter slice.
//  - DataW / StrbW : memory interface data and strobe widths.
//  - in_window()   : address window check against an aligned base.
package scarv_soc_bram_arbiter_pkg;

    localparam int unsigned DataW = 32;
    localparam int unsigned StrbW = DataW / 8;

    // True when addr falls in the 2**lw byte window starting at base.
    // base is assumed aligned to the window size.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int unsigned lw);
        return (addr >> lw) == (base >> lw);
    endfunction

endpackage

// File: rtl/scarv_soc_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
//  req  : request lines, one per port
//  en   : arbitration enable; win is 0 when low
//  last : index of the port that won most recently
//  win  : one-hot winner (0 when nothing requests)
module scarv_soc_rr_arb2 (
    input  logic [1:0] req,
    input  logic       en,
    input  logic       last,
    output logic [1:0] win
);

    always_comb begin
        win = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   win = 2'b01;
                2'b10:   win = 2'b10;
                2'b11:   win = last ? 2'b01 : 2'b10;
                default: win = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/scarv_soc_bram_arbiter.sv
// Shares one BRAM port between two req/gnt + recv/ack requesters.
//  clka, rsta          : clock, synchronous active-high reset
//  rN_req/wen/strb/addr/wdata : request from requester N
//  rN_gnt              : request accepted this cycle (combinational)
//  rN_recv/error/rdata : response to requester N, held until rN_ack
//  bram_en/we/addr/din : BRAM port controls (combinational)
//  bram_dout           : BRAM read data, valid the cycle after bram_en
module scarv_soc_bram_arbiter
    import scarv_soc_bram_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter logic [31:0] BASE  = 32'h0000_0000,
    localparam int unsigned LW   = $clog2(DEPTH)
) (
    input  logic             clka,
    input  logic             rsta,
    input  logic             r0_req,
    input  logic             r0_wen,
    input  logic [StrbW-1:0] r0_strb,
    input  logic [31:0]      r0_addr,
    input  logic [DataW-1:0] r0_wdata,
    output logic             r0_gnt,
    output logic             r0_recv,
    input  logic             r0_ack,
    output logic             r0_error,
    output logic [DataW-1:0] r0_rdata,
    input  logic             r1_req,
    input  logic             r1_wen,
    input  logic [StrbW-1:0] r1_strb,
    input  logic [31:0]      r1_addr,
    input  logic [DataW-1:0] r1_wdata,
    output logic             r1_gnt,
    output logic             r1_recv,
    input  logic             r1_ack,
    output logic             r1_error,
    output logic [DataW-1:0] r1_rdata,
    output logic             bram_en,
    output logic [StrbW-1:0] bram_we,
    output logic [LW-1:0]    bram_addr,
    output logic [DataW-1:0] bram_din,
    input  logic [DataW-1:0] bram_dout
);

    typedef enum logic {StIdle = 1'b0, StRsp = 1'b1} state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic             err_q, err_d;
    logic             rd_q, rd_d;      // response carries BRAM read data
    logic             fresh_q, fresh_d; // first RSP cycle: bram_dout is live
    logic [DataW-1:0] hold_q, hold_d;

    logic             can_issue;
    logic [1:0]       win;
    logic             w;
    logic             sel_wen;
    logic [StrbW-1:0] sel_strb;
    logic [31:0]      sel_addr;
    logic [DataW-1:0] sel_wdata;
    logic             hit;
    logic [DataW-1:0] rsp_data;

    // In RSP the owner's recv is always high, so only its ack matters.
    // Reset blocks any grant in the reset cycle.
    assign can_issue = !rsta &&
                       ((state_q == StIdle) || (owner_q ? r1_ack : r0_ack));

    scarv_soc_rr_arb2 u_arb (
        .req  ({r1_req, r0_req}),
        .en   (can_issue),
        .last (last_q),
        .win  (win)
    );

    assign r0_gnt = win[0];
    assign r1_gnt = win[1];
    assign w      = win[1];

    assign sel_wen   = w ? r1_wen   : r0_wen;
    assign sel_strb  = w ? r1_strb  : r0_strb;
    assign sel_addr  = w ? r1_addr  : r0_addr;
    assign sel_wdata = w ? r1_wdata : r0_wdata;
    assign hit       = in_window(sel_addr, BASE, LW);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        err_d     = err_q;
        rd_d      = rd_q;
        fresh_d   = fresh_q;
        hold_d    = hold_q;
        bram_en   = 1'b0;
        bram_we   = '0;
        bram_addr = '0;
        bram_din  = '0;

        // Capture read data so it stays stable while the owner stalls ack.
        if (state_q == StRsp && fresh_q) begin
            hold_d  = bram_dout;
            fresh_d = 1'b0;
        end

        if (can_issue) begin
            if (|win) begin
                state_d = StRsp;
                last_d  = w;
                owner_d = w;
                err_d   = !hit;
                rd_d    = hit && !sel_wen;
                fresh_d = 1'b1;
                if (hit) begin
                    bram_en   = 1'b1;
                    bram_we   = sel_wen ? sel_strb : '0;
                    bram_addr = sel_addr[LW-1:0];
                    bram_din  = sel_wdata;
                end
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            fresh_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            fresh_q <= fresh_d;
            hold_q  <= hold_d;
        end
    end

    // Response mux: only the owner sees recv; everything else reads as 0.
    assign rsp_data = rd_q ? (fresh_q ? bram_dout : hold_q) : '0;
    assign r0_recv  = (state_q == StRsp) && !owner_q;
    assign r1_recv  = (state_q == StRsp) && owner_q;
    assign r0_error = r0_recv && err_q;
    assign r1_error = r1_recv && err_q;
    assign r0_rdata = r0_recv ? rsp_data : '0;
    assign r1_rdata = r1_recv ? rsp_data : '0;

endmodule

// File: tb/tb_scarv_soc_bram_arbiter.sv
module tb_scarv_soc_bram_arbiter;

    logic        clka = 1'b0;
    logic        rsta;
    logic        r0_req, r0_wen, r0_ack, r0_gnt, r0_recv, r0_error;
    logic [3:0]  r0_strb;
    logic [31:0] r0_addr, r0_wdata, r0_rdata;
    logic        r1_req, r1_wen, r1_ack, r1_gnt, r1_recv, r1_error;
    logic [3:0]  r1_strb;
    logic [31:0] r1_addr, r1_wdata, r1_rdata;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [9:0]  bram_addr;
    logic [31:0] bram_din;
    logic [31:0] bram_dout = 32'h0;

    int total = 0;
    int bad   = 0;

    logic [31:0] bram_mem [0:255];
    logic [31:0] ref_mem  [0:255];

    always #5 clka = ~clka;

    scarv_soc_bram_arbiter #(.DEPTH(1024), .BASE(32'h0)) dut (
        .clka      (clka),
        .rsta      (rsta),
        .r0_req    (r0_req),
        .r0_wen    (r0_wen),
        .r0_strb   (r0_strb),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_gnt    (r0_gnt),
        .r0_recv   (r0_recv),
        .r0_ack    (r0_ack),
        .r0_error  (r0_error),
        .r0_rdata  (r0_rdata),
        .r1_req    (r1_req),
        .r1_wen    (r1_wen),
        .r1_strb   (r1_strb),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r1_gnt    (r1_gnt),
        .r1_recv   (r1_recv),
        .r1_ack    (r1_ack),
        .r1_error  (r1_error),
        .r1_rdata  (r1_rdata),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_dout (bram_dout)
    );

    // BRAM port: registered read, byte-enabled write, dout held while idle.
    always @(posedge clka) begin
        if (bram_en) begin
            bram_dout <= bram_mem[bram_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) bram_mem[bram_addr[9:2]][8*b +: 8] <= bram_din[8*b +: 8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    // Transaction-level model: at most one outstanding response, tracked as
    // (port, error, data); read data comes from a reference memory updated at grant.
    logic        pv, pp, pe, lastm, ci, any, wm, wwen, whit;
    logic [31:0] pd, waddr, wdat;
    logic [3:0]  wstrb;

    initial begin : model
        pv = 1'b0; pp = 1'b0; pe = 1'b0; pd = 32'h0; lastm = 1'b1;
        forever begin
            @(negedge clka);
            chk("m_r0_recv",  {31'h0, r0_recv},  {31'h0, pv && !pp});
            chk("m_r1_recv",  {31'h0, r1_recv},  {31'h0, pv && pp});
            chk("m_r0_error", {31'h0, r0_error}, {31'h0, pv && !pp && pe});
            chk("m_r1_error", {31'h0, r1_error}, {31'h0, pv && pp && pe});
            chk("m_r0_rdata", r0_rdata, (pv && !pp) ? pd : 32'h0);
            chk("m_r1_rdata", r1_rdata, (pv && pp) ? pd : 32'h0);

            ci  = !rsta && (!pv || (pp ? r1_ack : r0_ack));
            any = ci && (r0_req || r1_req);
            wm  = (r0_req && r1_req) ? !lastm : r1_req;
            chk("m_r0_gnt", {31'h0, r0_gnt}, {31'h0, any && !wm});
            chk("m_r1_gnt", {31'h0, r1_gnt}, {31'h0, any && wm});

            wwen  = wm ? r1_wen   : r0_wen;
            waddr = wm ? r1_addr  : r0_addr;
            wdat  = wm ? r1_wdata : r0_wdata;
            wstrb = wm ? r1_strb  : r0_strb;
            whit  = (waddr < 32'd1024);
            chk("m_bram_en", {31'h0, bram_en}, {31'h0, any && whit});
            if (any && whit) begin
                chk("m_bram_we",   {28'h0, bram_we}, {28'h0, wwen ? wstrb : 4'h0});
                chk("m_bram_addr", {22'h0, bram_addr}, {22'h0, waddr[9:0]});
                chk("m_bram_din",  bram_din, wdat);
            end else if (!any) begin
                chk("m_bram_idle", {bram_din[27:0], bram_we}, 32'h0);
            end

            if (rsta) begin
                pv = 1'b0;
                lastm = 1'b1;
            end else if (ci) begin
                if (any) begin
                    pv = 1'b1; pp = wm; pe = !whit; lastm = wm;
                    pd = (whit && !wwen) ? ref_mem[waddr[9:2]] : 32'h0;
                    if (whit && wwen)
                        for (int b = 0; b < 4; b++)
                            if (wstrb[b]) ref_mem[waddr[9:2]][8*b +: 8] = wdat[8*b +: 8];
                end else begin
                    pv = 1'b0;
                end
            end
        end
    end

    initial begin : stim
        for (int i = 0; i < 256; i++) begin
            bram_mem[i] = 32'hC0DE_0000 | i;
            ref_mem[i]  = 32'hC0DE_0000 | i;
        end
        bram_mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
        bram_mem[5] = 32'h12345678; ref_mem[5] = 32'h12345678;
        bram_mem[8] = 32'hAABBCCDD; ref_mem[8] = 32'hAABBCCDD;
        rsta = 1'b1;
        r0_req = 0; r0_wen = 0; r0_strb = 4'hF; r0_addr = 0; r0_wdata = 0; r0_ack = 0;
        r1_req = 0; r1_wen = 0; r1_strb = 4'hF; r1_addr = 0; r1_wdata = 0; r1_ack = 0;
        step(); step();
        @(negedge clka);
        chk("rst_r0_recv", {31'h0, r0_recv}, 32'h0);
        chk("rst_r1_rdata", r1_rdata, 32'h0);
        step();
        rsta = 1'b0;

        // 1: single read, ack held high
        r0_ack = 1; r1_ack = 1; r0_req = 1; r0_addr = 32'h10;
        @(negedge clka);
        chk("t1_gnt", {31'h0, r0_gnt}, 32'h1);
        step(); r0_req = 0;
        @(negedge clka);
        chk("t1_recv", {31'h0, r0_recv}, 32'h1);
        chk("t1_rdata", r0_rdata, 32'hDEADBEEF);
        chk("t1_r1_recv", {31'h0, r1_recv}, 32'h0);
        step();

        // 2: both request every cycle; last=0 so port 1 goes first
        r0_req = 1; r1_req = 1; r1_addr = 32'h14;
        for (int k = 0; k < 4; k++) begin
            @(negedge clka);
            chk("t2_r1_gnt", {31'h0, r1_gnt}, (k % 2 == 0) ? 32'h1 : 32'h0);
            chk("t2_r0_gnt", {31'h0, r0_gnt}, (k % 2 == 1) ? 32'h1 : 32'h0);
            step();
        end
        r0_req = 0; r1_req = 0;
        @(negedge clka);
        chk("t2_last_rdata", r0_rdata, 32'hDEADBEEF);
        step();

        // 3: partial write then back-to-back read of the same word
        r1_req = 1; r1_wen = 1; r1_addr = 32'h20; r1_wdata = 32'h11223344; r1_strb = 4'b0101;
        @(negedge clka);
        chk("t3_wr_gnt", {31'h0, r1_gnt}, 32'h1);
        step(); r1_req = 0; r1_wen = 0; r1_strb = 4'hF; r0_req = 1; r0_addr = 32'h20;
        @(negedge clka);
        chk("t3_rd_gnt", {31'h0, r0_gnt}, 32'h1);
        chk("t3_wr_rdata", r1_rdata, 32'h0);
        step(); r0_req = 0;
        @(negedge clka);
        chk("t3_rdata", r0_rdata, 32'hAA22CC44);
        step();

        // 4: owner stalls ack while port 1 waits
        r0_req = 1; r0_addr = 32'h10; r0_ack = 0;
        @(negedge clka);
        chk("t4_gnt", {31'h0, r0_gnt}, 32'h1);
        step(); r0_req = 0; r1_req = 1; r1_addr = 32'h14;
        for (int k = 0; k < 5; k++) begin
            @(negedge clka);
            chk("t4_stall_rdata", r0_rdata, 32'hDEADBEEF);
            chk("t4_stall_r1_gnt", {31'h0, r1_gnt}, 32'h0);
            step();
        end
        r0_ack = 1;
        @(negedge clka);
        chk("t4_ack_r1_gnt", {31'h0, r1_gnt}, 32'h1);
        step(); r1_req = 0;
        @(negedge clka);
        chk("t4_r1_recv", {31'h0, r1_recv}, 32'h1);
        chk("t4_r1_rdata", r1_rdata, 32'h12345678);
        step();

        // 5: out-of-window read, then out-of-window write aliasing word 0x10
        r0_req = 1; r0_addr = 32'h400;
        @(negedge clka);
        chk("t5_bram_en", {31'h0, bram_en}, 32'h0);
        step(); r0_wen = 1; r0_addr = 32'h410; r0_wdata = 32'hFFFFFFFF;
        @(negedge clka);
        chk("t5_error", {31'h0, r0_error}, 32'h1);
        chk("t5_rdata", r0_rdata, 32'h0);
        step(); r0_wen = 0; r0_addr = 32'h10;
        step(); r0_req = 0;
        @(negedge clka);
        chk("t5_untouched", r0_rdata, 32'hDEADBEEF);
        step();

        // 6: reset with a response pending
        r0_req = 1; r0_addr = 32'h14;
        @(negedge clka);
        chk("t6_gnt", {31'h0, r0_gnt}, 32'h1);
        step(); rsta = 1; r0_req = 0; r1_req = 1; r1_addr = 32'h20;
        @(negedge clka);
        chk("t6_rst_no_gnt", {31'h0, r1_gnt}, 32'h0);
        step(); rsta = 0; r1_req = 0;
        @(negedge clka);
        chk("t6_recv_dropped", {31'h0, r0_recv}, 32'h0);
        step(); r0_req = 1; r0_addr = 32'h20; r1_req = 1; r1_addr = 32'h14;
        @(negedge clka);
        chk("t6_first_gnt_r0", {31'h0, r0_gnt}, 32'h1);
        step(); r0_req = 0;
        @(negedge clka);
        chk("t6_rdata", r0_rdata, 32'hAA22CC44);
        chk("t6_r1_gnt", {31'h0, r1_gnt}, 32'h1);
        step(); r1_req = 0;
        @(negedge clka);
        chk("t6_r1_rdata", r1_rdata, 32'h12345678);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
